// File: rtl/evp_horner_multiset.sv
// -----------------------------------------------------------------------------
// evp_horner_multiset
//   Polynomial evaluation engine. Holds NUM_SETS independent coefficient sets
//   and evaluates sum(c_i * x^i), i = 0..N, by Horner's scheme with one MAC per
//   cycle. Each finished evaluation is pushed to the result/status FIFOs with a
//   one-cycle write strobe, honouring downstream back-pressure.
//
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   coef_wr_*      coefficient store write port (set, index, value)
//   start          evaluation request, sampled only while idle
//   set_sel        coefficient set to evaluate (latched on start)
//   degree         polynomial degree N (latched on start)
//   x_in           evaluation point x (latched on start)
//   out_full       downstream FIFO full; stalls the result write
//   busy           engine is not idle
//   wr_out         one-cycle write strobe to the result and status FIFOs
//   result_out     polynomial value, valid while wr_out = 1
//   status_out     [0] overflow, [1] bad degree, [2] write conflict
//   done           one-cycle completion pulse, coincident with wr_out
// -----------------------------------------------------------------------------
module evp_horner_multiset #(
   parameter int WIDTH     = 16,
   parameter int ACC_WIDTH = 32,
   parameter int MAX_N     = 10,
   parameter int NUM_SETS  = 4,
   parameter int SB        = 2,
   parameter int IB        = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 coef_wr_en,
   input  logic [SB-1:0]        coef_wr_set,
   input  logic [IB-1:0]        coef_wr_idx,
   input  logic [WIDTH-1:0]     coef_wr_data,
   input  logic                 start,
   input  logic [SB-1:0]        set_sel,
   input  logic [IB-1:0]        degree,
   input  logic [WIDTH-1:0]     x_in,
   input  logic                 out_full,
   output logic                 busy,
   output logic                 wr_out,
   output logic [ACC_WIDTH-1:0] result_out,
   output logic [2:0]           status_out,
   output logic                 done
);

   localparam int unsigned NUM_COEF = MAX_N + 1;
   localparam int          PW       = ACC_WIDTH + WIDTH;
   localparam logic [IB-1:0] MAX_N_IB = IB'(MAX_N);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE} state_t;

   state_t state, state_nx;

   logic signed [WIDTH-1:0]     coef [NUM_SETS][NUM_COEF];
   logic signed [WIDTH-1:0]     coef_rd;
   logic [SB-1:0]               rd_set;
   logic [IB-1:0]               rd_idx;

   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [WIDTH-1:0]     x_q;
   logic [IB-1:0]               idx_q;
   logic [SB-1:0]               set_q;
   logic [2:0]                  flags;

   logic signed [PW-1:0]        prod;
   logic signed [PW-1:0]        sum;
   logic                        ovf;
   logic                        bad_deg;
   logic                        idx_ok;
   logic                        conflict;
   logic                        wr_accept;
   logic [2:0]                  flags_now;

   assign busy      = (state != S_IDLE);
   assign bad_deg   = (degree > MAX_N_IB);
   assign idx_ok    = (coef_wr_idx <= MAX_N_IB);
   // A write aimed at the set being evaluated is dropped and flagged so the
   // evaluation never sees a mix of old and new coefficients.
   assign conflict  = coef_wr_en && busy && (coef_wr_set == set_q);
   assign wr_accept = coef_wr_en && idx_ok && !conflict;
   assign flags_now = flags | {conflict, 2'b00};

   // Read address: the top coefficient when starting, then c[idx-1] while in MAC.
   always_comb begin
      rd_set = set_q;
      rd_idx = idx_q - IB'(1);
      if (state == S_IDLE) begin
         rd_set = set_sel;
         rd_idx = degree;
      end
   end

   always_comb begin
      coef_rd = '0;
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
         for (int unsigned i = 0; i < NUM_COEF; i++) begin
            if (rd_set == SB'(s) && rd_idx == IB'(i)) begin
               coef_rd = coef[s][i];
            end
         end
      end
   end

   // Full-width MAC; overflow is any intermediate outside the signed ACC range.
   always_comb begin
      prod = PW'(acc) * PW'(x_q);
      sum  = prod + PW'(coef_rd);
      ovf  = (prod[PW-1:ACC_WIDTH-1] != {(WIDTH+1){prod[PW-1]}}) ||
             (sum[PW-1:ACC_WIDTH-1]  != {(WIDTH+1){sum[PW-1]}});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned s = 0; s < NUM_SETS; s++) begin
            for (int unsigned i = 0; i < NUM_COEF; i++) begin
               coef[s][i] <= '0;
            end
         end
      end else if (wr_accept) begin
         for (int unsigned s = 0; s < NUM_SETS; s++) begin
            for (int unsigned i = 0; i < NUM_COEF; i++) begin
               if (coef_wr_set == SB'(s) && coef_wr_idx == IB'(i)) begin
                  coef[s][i] <= coef_wr_data;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (bad_deg || degree == '0) begin
                  state_nx = S_WRITE;
               end else begin
                  state_nx = S_MAC;
               end
            end
         end
         S_MAC: begin
            if (idx_q == IB'(1)) begin
               state_nx = S_WRITE;
            end
         end
         S_WRITE: begin
            if (!out_full) begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         x_q        <= '0;
         idx_q      <= '0;
         set_q      <= '0;
         flags      <= '0;
         wr_out     <= 1'b0;
         done       <= 1'b0;
         result_out <= '0;
         status_out <= '0;
      end else begin
         wr_out <= 1'b0;
         done   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  set_q <= set_sel;
                  x_q   <= x_in;
                  if (bad_deg) begin
                     acc   <= '0;
                     idx_q <= '0;
                     flags <= 3'b010;
                  end else begin
                     acc   <= ACC_WIDTH'(coef_rd);
                     idx_q <= degree;
                     flags <= '0;
                  end
               end
            end
            S_MAC: begin
               acc   <= sum[ACC_WIDTH-1:0];
               idx_q <= idx_q - IB'(1);
               flags <= {flags_now[2], flags_now[1], flags_now[0] | ovf};
            end
            S_WRITE: begin
               flags <= flags_now;
               if (!out_full) begin
                  wr_out     <= 1'b1;
                  done       <= 1'b1;
                  result_out <= acc;
                  status_out <= flags_now;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
